// File: rtl/nfc_command_arbiter.sv
// Fixed-priority, non-preemptive arbiter sharing one atomic command generator (ACG)
// among several NAND command sequencers, with host ready aggregation and a hang watchdog.
module nfc_command_arbiter #(
  parameter int unsigned NumberOfCmds  = 4,
  parameter int unsigned NumberOfWays  = 4,
  parameter logic [31:0] TimeoutCycles = 32'd1000000
) (
  input  logic                                 iSystemClock,
  input  logic                                 iReset,

  input  logic [NumberOfCmds-1:0]              iCmd_Start,
  input  logic [NumberOfCmds-1:0]              iCmd_LastStep,
  input  logic [NumberOfCmds-1:0]              iCmd_CMDReady,
  input  logic [8*NumberOfCmds-1:0]            iCmd_ACG_Command,
  input  logic [3*NumberOfCmds-1:0]            iCmd_ACG_CommandOption,
  input  logic [NumberOfWays*NumberOfCmds-1:0] iCmd_ACG_TargetWay,
  input  logic [16*NumberOfCmds-1:0]           iCmd_ACG_NumOfData,
  input  logic [NumberOfCmds-1:0]              iCmd_ACG_CASelect,
  input  logic [40*NumberOfCmds-1:0]           iCmd_ACG_CAData,
  output logic [8*NumberOfCmds-1:0]            oCmd_ACG_Ready,
  output logic [8*NumberOfCmds-1:0]            oCmd_ACG_LastStep,

  output logic [7:0]                           oACG_Command,
  output logic [2:0]                           oACG_CommandOption,
  output logic [NumberOfWays-1:0]              oACG_TargetWay,
  output logic [15:0]                          oACG_NumOfData,
  output logic                                 oACG_CASelect,
  output logic [39:0]                          oACG_CAData,
  input  logic [7:0]                           iACG_Ready,
  input  logic [7:0]                           iACG_LastStep,

  output logic                                 oCMDReady,
  output logic [NumberOfCmds-1:0]              oOwner,
  output logic                                 oBusy,
  output logic                                 oLastStep,
  output logic                                 oTimeout,
  output logic                                 oCollision
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  logic [0:0]              r_state;
  logic [NumberOfCmds-1:0] r_owner;
  logic                    r_last_step;
  logic                    r_timeout;
  logic                    r_collision;
  logic [31:0]             r_wdog;

  logic [NumberOfCmds-1:0] w_start_lowest;
  logic                    w_any_start;
  logic                    w_multi_start;
  logic                    w_busy;
  logic                    w_owner_done;
  logic                    w_wdog_expire;

  // x & -x isolates the lowest set bit, i.e. the highest-priority requester.
  assign w_start_lowest = iCmd_Start & (~iCmd_Start + NumberOfCmds'(1));
  assign w_any_start    = |iCmd_Start;
  assign w_multi_start  = |(iCmd_Start & (iCmd_Start - NumberOfCmds'(1)));
  assign w_busy         = (r_state == StBusy);
  assign w_owner_done   = w_busy && (|(iCmd_LastStep & r_owner));
  assign w_wdog_expire  = w_busy && !w_owner_done && (r_wdog == (TimeoutCycles - 32'd1));

  always_ff @(posedge iSystemClock or posedge iReset) begin
    if (iReset) begin
      r_state     <= StIdle;
      r_owner     <= '0;
      r_last_step <= 1'b0;
      r_timeout   <= 1'b0;
      r_collision <= 1'b0;
      r_wdog      <= '0;
    end else begin
      r_last_step <= 1'b0;
      r_timeout   <= 1'b0;
      case (r_state)
        StIdle: begin
          r_wdog <= '0;
          if (w_any_start) begin
            r_state <= StBusy;
            r_owner <= w_start_lowest;
            if (w_multi_start) begin
              r_collision <= 1'b1;
            end
          end
        end
        StBusy: begin
          // Any start while the ACG is held is dropped; the host must wait for oCMDReady.
          if (w_any_start) begin
            r_collision <= 1'b1;
          end
          if (w_owner_done) begin
            r_state     <= StIdle;
            r_owner     <= '0;
            r_last_step <= 1'b1;
            r_wdog      <= '0;
          end else if (w_wdog_expire) begin
            r_state   <= StIdle;
            r_owner   <= '0;
            r_timeout <= 1'b1;
            r_wdog    <= '0;
          end else if (r_wdog != 32'hFFFF_FFFF) begin
            r_wdog <= r_wdog + 32'd1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_owner <= '0;
        end
      endcase
    end
  end

  // Owner is one-hot while busy, so at most one slice is selected.
  always_comb begin
    oACG_Command       = 8'h00;
    oACG_CommandOption = 3'b000;
    oACG_TargetWay     = '0;
    oACG_NumOfData     = 16'h0000;
    oACG_CASelect      = 1'b1;
    oACG_CAData        = 40'h00_0000_0000;
    if (w_busy) begin
      for (int k = 0; k < int'(NumberOfCmds); k++) begin
        if (r_owner[k]) begin
          oACG_Command       = iCmd_ACG_Command[8*k +: 8];
          oACG_CommandOption = iCmd_ACG_CommandOption[3*k +: 3];
          oACG_TargetWay     = iCmd_ACG_TargetWay[NumberOfWays*k +: NumberOfWays];
          oACG_NumOfData     = iCmd_ACG_NumOfData[16*k +: 16];
          oACG_CASelect      = iCmd_ACG_CASelect[k];
          oACG_CAData        = iCmd_ACG_CAData[40*k +: 40];
        end
      end
    end
  end

  always_comb begin
    oCmd_ACG_Ready    = '0;
    oCmd_ACG_LastStep = '0;
    for (int k = 0; k < int'(NumberOfCmds); k++) begin
      if (r_owner[k]) begin
        oCmd_ACG_Ready[8*k +: 8]    = iACG_Ready;
        oCmd_ACG_LastStep[8*k +: 8] = iACG_LastStep;
      end
    end
  end

  assign oCMDReady  = (r_state == StIdle) && (&iCmd_CMDReady);
  assign oOwner     = r_owner;
  assign oBusy      = w_busy;
  assign oLastStep  = r_last_step;
  assign oTimeout   = r_timeout;
  assign oCollision = r_collision;

endmodule

// File: tb/tb_nfc_command_arbiter.sv
// Directed bench for nfc_command_arbiter: expected grants go through a scoreboard queue,
// all other expectations are constants derived from the stimulus.
module tb_nfc_command_arbiter;
  localparam int unsigned NC = 4;
  localparam int unsigned NW = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NC-1:0]     iCmd_Start = '0, iCmd_LastStep = '0, iCmd_CMDReady = '1;
  logic [8*NC-1:0]   iCmd_ACG_Command;
  logic [3*NC-1:0]   iCmd_ACG_CommandOption;
  logic [NW*NC-1:0]  iCmd_ACG_TargetWay;
  logic [16*NC-1:0]  iCmd_ACG_NumOfData;
  logic [NC-1:0]     iCmd_ACG_CASelect;
  logic [40*NC-1:0]  iCmd_ACG_CAData;
  logic [8*NC-1:0]   oCmd_ACG_Ready, oCmd_ACG_LastStep;
  logic [7:0]        oACG_Command;
  logic [2:0]        oACG_CommandOption;
  logic [NW-1:0]     oACG_TargetWay;
  logic [15:0]       oACG_NumOfData;
  logic              oACG_CASelect;
  logic [39:0]       oACG_CAData;
  logic [7:0]        iACG_Ready = '0, iACG_LastStep = '0;
  logic              oCMDReady, oBusy, oLastStep, oTimeout, oCollision;
  logic [NC-1:0]     oOwner;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [NC-1:0] exp_owner_q[$];

  always #5 clk = ~clk;

  nfc_command_arbiter #(
    .NumberOfCmds (NC),
    .NumberOfWays (NW),
    .TimeoutCycles(32'd16)
  ) dut (
    .iSystemClock          (clk),
    .iReset                (rst),
    .iCmd_Start            (iCmd_Start),
    .iCmd_LastStep         (iCmd_LastStep),
    .iCmd_CMDReady         (iCmd_CMDReady),
    .iCmd_ACG_Command      (iCmd_ACG_Command),
    .iCmd_ACG_CommandOption(iCmd_ACG_CommandOption),
    .iCmd_ACG_TargetWay    (iCmd_ACG_TargetWay),
    .iCmd_ACG_NumOfData    (iCmd_ACG_NumOfData),
    .iCmd_ACG_CASelect     (iCmd_ACG_CASelect),
    .iCmd_ACG_CAData       (iCmd_ACG_CAData),
    .oCmd_ACG_Ready        (oCmd_ACG_Ready),
    .oCmd_ACG_LastStep     (oCmd_ACG_LastStep),
    .oACG_Command          (oACG_Command),
    .oACG_CommandOption    (oACG_CommandOption),
    .oACG_TargetWay        (oACG_TargetWay),
    .oACG_NumOfData        (oACG_NumOfData),
    .oACG_CASelect         (oACG_CASelect),
    .oACG_CAData           (oACG_CAData),
    .iACG_Ready            (iACG_Ready),
    .iACG_LastStep         (iACG_LastStep),
    .oCMDReady             (oCMDReady),
    .oOwner                (oOwner),
    .oBusy                 (oBusy),
    .oLastStep             (oLastStep),
    .oTimeout              (oTimeout),
    .oCollision            (oCollision)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_start(input logic [NC-1:0] s, input logic [NC-1:0] exp_owner);
    iCmd_Start = s;
    exp_owner_q.push_back(exp_owner);
    tick();
    iCmd_Start = '0;
  endtask

  task automatic check_grant(input string tag);
    if (exp_owner_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s: scoreboard empty, observed owner %0h", tag, oOwner);
    end else begin
      chk(tag, 64'(oOwner), 64'(exp_owner_q.pop_front()));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_owner"}, 64'(oOwner), 64'h0);
    chk({tag, "_busy"}, 64'(oBusy), 64'h0);
    chk({tag, "_cmd"}, 64'(oACG_Command), 64'h0);
    chk({tag, "_cas"}, 64'(oACG_CASelect), 64'h1);
    chk({tag, "_cadata"}, 64'(oACG_CAData), 64'h0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    for (int k = 0; k < int'(NC); k++) begin
      iCmd_ACG_Command[8*k +: 8]        = 8'h10 + 8'(k);
      iCmd_ACG_CommandOption[3*k +: 3]  = 3'(k + 1);
      iCmd_ACG_TargetWay[NW*k +: NW]    = NW'(1 << k);
      iCmd_ACG_NumOfData[16*k +: 16]    = 16'h0100 + 16'(k);
      iCmd_ACG_CASelect[k]              = k[0];
      iCmd_ACG_CAData[40*k +: 40]       = 40'hA0_0000_0000 + 40'(k);
    end

    // Reset values
    #1 rst = 1'b1;
    #1;
    check_idle_outputs("rst");
    chk("rst_laststep", 64'(oLastStep), 64'h0);
    chk("rst_timeout", 64'(oTimeout), 64'h0);
    chk("rst_collision", 64'(oCollision), 64'h0);
    chk("rst_cmdready", 64'(oCMDReady), 64'h1);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Single erase on sequencer 2
    drive_start(4'b0100, 4'b0100);
    check_grant("t1_grant");
    chk("t1_busy", 64'(oBusy), 64'h1);
    chk("t1_cmdready", 64'(oCMDReady), 64'h0);
    chk("t1_cmd", 64'(oACG_Command), 64'h12);
    chk("t1_opt", 64'(oACG_CommandOption), 64'h3);
    chk("t1_way", 64'(oACG_TargetWay), 64'h4);
    chk("t1_nod", 64'(oACG_NumOfData), 64'h0102);
    chk("t1_cas", 64'(oACG_CASelect), 64'h0);
    chk("t1_cadata", 64'(oACG_CAData), 64'hA0_0000_0002);
    iACG_Ready    = 8'h5A;
    iACG_LastStep = 8'h3C;
    #1;
    chk("t1_ready_route", 64'(oCmd_ACG_Ready), 64'h005A_0000);
    chk("t1_last_route", 64'(oCmd_ACG_LastStep), 64'h003C_0000);
    for (int i = 1; i <= 9; i++) begin
      chk("t1_hold_owner", 64'(oOwner), 64'h4);
      tick();
    end
    iCmd_LastStep = 4'b0100;
    chk("t1_owner_t10", 64'(oOwner), 64'h4);
    tick();
    iCmd_LastStep = '0;
    check_idle_outputs("t1_release");
    chk("t1_laststep_pulse", 64'(oLastStep), 64'h1);
    chk("t1_cmdready_back", 64'(oCMDReady), 64'h1);
    chk("t1_ready_route_idle", 64'(oCmd_ACG_Ready), 64'h0);
    tick();
    chk("t1_laststep_end", 64'(oLastStep), 64'h0);
    chk("t1_no_collision", 64'(oCollision), 64'h0);

    // Last-step and start in the same cycle: completion wins, start not granted
    drive_start(4'b0100, 4'b0100);
    check_grant("sc_grant");
    iCmd_LastStep = 4'b0100;
    drive_start(4'b0010, 4'b0000);
    iCmd_LastStep = '0;
    check_grant("sc_no_grant");
    chk("sc_collision", 64'(oCollision), 64'h1);
    chk("sc_laststep", 64'(oLastStep), 64'h1);
    tick();
    chk("sc_still_idle", 64'(oBusy), 64'h0);

    // Simultaneous starts in IDLE
    do_reset();
    chk("t2_collision_cleared", 64'(oCollision), 64'h0);
    drive_start(4'b1010, 4'b0010);
    check_grant("t2_grant");
    chk("t2_collision", 64'(oCollision), 64'h1);
    iCmd_LastStep = 4'b0010;
    tick();
    iCmd_LastStep = '0;
    tick();
    chk("t2_collision_sticky", 64'(oCollision), 64'h1);
    chk("t2_idle", 64'(oBusy), 64'h0);

    // Start and foreign last-step while sequencer 0 owns
    do_reset();
    drive_start(4'b0001, 4'b0001);
    check_grant("t3_grant");
    chk("t3_collision0", 64'(oCollision), 64'h0);
    drive_start(4'b1000, 4'b0001);
    check_grant("t3_busy_start");
    chk("t3_collision1", 64'(oCollision), 64'h1);
    iCmd_LastStep = 4'b1000;
    tick();
    iCmd_LastStep = '0;
    chk("t3_foreign_last_owner", 64'(oOwner), 64'h1);
    chk("t3_foreign_last_busy", 64'(oBusy), 64'h1);
    chk("t3_foreign_last_pulse", 64'(oLastStep), 64'h0);
    iCmd_LastStep = 4'b0001;
    tick();
    iCmd_LastStep = '0;
    chk("t3_release", 64'(oBusy), 64'h0);

    // Back-to-back: seq 1 completes, seq 0 starts the next cycle
    drive_start(4'b0010, 4'b0010);
    check_grant("b2b_grant1");
    iCmd_LastStep = 4'b0010;
    tick();
    iCmd_LastStep = '0;
    chk("b2b_laststep", 64'(oLastStep), 64'h1);
    chk("b2b_owner_clear", 64'(oOwner), 64'h0);
    chk("b2b_cmdready", 64'(oCMDReady), 64'h1);
    drive_start(4'b0001, 4'b0001);
    check_grant("b2b_grant0");
    chk("b2b_laststep_end", 64'(oLastStep), 64'h0);
    chk("b2b_cmd", 64'(oACG_Command), 64'h10);
    iCmd_LastStep = 4'b0001;
    tick();
    iCmd_LastStep = '0;

    // Watchdog release after 16 BUSY cycles
    do_reset();
    drive_start(4'b1000, 4'b1000);
    check_grant("to_grant");
    for (int i = 1; i <= 16; i++) begin
      chk("to_busy_phase", 64'({oBusy, oTimeout}), 64'h2);
      tick();
    end
    chk("to_pulse", 64'(oTimeout), 64'h1);
    check_idle_outputs("to_idle");
    chk("to_cmdready", 64'(oCMDReady), 64'h1);
    tick();
    chk("to_pulse_end", 64'(oTimeout), 64'h0);

    // Asynchronous reset mid-BUSY
    drive_start(4'b0010, 4'b0010);
    check_grant("ar_grant");
    iACG_Ready = 8'hC3;
    #2 rst = 1'b1;
    #1;
    check_idle_outputs("ar_async");
    chk("ar_ready_route", 64'(oCmd_ACG_Ready), 64'h0);
    chk("ar_collision", 64'(oCollision), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    drive_start(4'b0100, 4'b0100);
    check_grant("ar_regrant");
    chk("ar_regrant_busy", 64'(oBusy), 64'h1);
    #1;
    chk("ar_regrant_route", 64'(oCmd_ACG_Ready), 64'h00C3_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
